mul_issue_ctrl: RTL and testbench
=================================

Name: mul_issue_ctrl

Overview:
Control stage between the EXU's M-extension op decode and the 64-bit multiplier core (mul_valid/mul_ready/out_valid interface).
- Accepts one RV64M multiply op with its two source operands.
- Drives the core with `mulw`, `mul_signed`, `multiplicand` and `multiplier`.
- Captures the core's product and formats it into the 64-bit writeback value for MUL, MULH, MULHSU, MULHU and MULW.
- Holds that result under a valid/ready handshake toward writeback.

Parameters:
XLEN, 64, operand/result width; only 64 supported.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  pipeline flush; kills the in-flight op
in_valid  in  1  op request
in_ready  out  1  ctrl can accept an op
in_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
in_w  in  1  W-form (only legal with in_op=00)
in_src1  in  XLEN  rs1 value
in_src2  in  XLEN  rs2 value
mul_valid  out  1  request to core
mul_ready  in  1  core accepts request
mul_flush  out  1  flush forwarded to core
mulw  out  1  W-mode to core
mul_signed  out  2  [1]=multiplicand signed, [0]=multiplier signed
multiplicand  out  XLEN  = latched rs1
multiplier  out  XLEN  = latched rs2
out_valid  in  1  core result strobe (single-cycle pulse)
result_hi  in  XLEN  product bits 127:64
result_lo  in  XLEN  product bits 63:0
res_valid  out  1  formatted result available
res_ready  in  1  writeback accepts
res_data  out  XLEN  formatted result

Behaviour:
- Reset (rst=1 at posedge): state=IDLE. `in_ready`=1 after reset; `mul_valid`, `mul_flush`, `res_valid`=0; `res_data`, operand regs=0; `mulw`=0; `mul_signed`=00.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`&`in_ready`, latch op/w/src1/src2 and go to REQ.
  - REQ: `mul_valid`=1 with stable operands. On `mul_ready`, go to WAIT; `mul_valid` is deasserted the next cycle.
  - WAIT: on `out_valid`, latch the formatted result into `res_data` and go to DONE. `out_valid` in any other state is ignored.
  - DONE: `res_valid`=1, `res_data` held stable. On `res_ready`, go to IDLE.
- `in_ready`=1 only in IDLE, so there is no accept in the same cycle as a handoff.
- Signedness mapping: MUL→00, MULHU→00, MULHSU→10, MULH→11. W-form→00 with `mulw`=1; the low 32 bits are signedness-independent.
- Result select:
  - MUL: `result_lo`.
  - MULH/MULHSU/MULHU: `result_hi`.
  - MULW: `result_lo[31:0]` sign-extended from bit 31.
- Illegal `in_w`=1 with `in_op`≠00: treated as MULW.
- Latency, excluding core time: accept at T, `mul_valid` at T+1. `res_valid` is high the cycle after the `out_valid` pulse.
- Flush: in any state, return to IDLE on the next edge and clear `res_valid`.
  - If flush occurs in REQ or WAIT, `mul_flush`=1 for exactly one cycle.
  - Flush and `in_valid` in the same cycle: the op is not accepted.
  - Flush has priority over `out_valid` and `res_ready`.
- `rst` mid-operation: same effect as flush, but `mul_flush` is not pulsed; the core is reset by the same `rst`.

Optional Feature:
MUL_RESULT_REUSE_EN
- With the macro defined:
  - Keep the last full 128-bit product, its {src1, src2, mul_signed, mulw} tag and a valid bit.
  - On accept, on a tag match, go directly to DONE (`res_valid` at T+1) with no core request.
  - MUL (non-W) matches on src1/src2 with any non-W signedness; this covers the MULH-then-MUL sequence.
  - The valid bit is cleared by `rst` and set only on a captured `out_valid`. Flush does not clear it.
- Without the macro: every op issues to the core, and there is no product/tag storage.

Decomposition:
- Package mul_pkg:
  - Op encodings (MUL_OP_MUL/MULH/MULHSU/MULHU).
  - FSM state typedef (IDLE/REQ/WAIT/DONE).
  - Signedness constants (SGN_UU=00, SGN_US=01, SGN_SU=10, SGN_SS=11).
- Sub-module mul_result_fmt (combinational): op, w, `result_hi`, `result_lo` → `res_data`. Shared with the reuse path.

Test Plan:
- MUL src1=5, src2=-1 → `res_data`=FFFFFFFF_FFFFFFFB, `mul_signed`=00, `mulw`=0.
- MULHU FFFFFFFF_FFFFFFFF × FFFFFFFF_FFFFFFFF → FFFFFFFF_FFFFFFFE. MULH on the same operands → 0.
- MULHSU src1=-1, src2=FFFFFFFF_FFFFFFFF → FFFFFFFF_FFFFFFFF with `mul_signed`=10. MULHSU 80000000_00000000 × 2 → FFFFFFFF_FFFFFFFF.
- MULW 00000000_7FFFFFFF × 2 → FFFFFFFF_FFFFFFFE, `mulw`=1. MULW 5 × 5 → 00000000_00000019.
- Back-pressure: hold `res_ready`=0 for 10 cycles → `res_valid`=1 and `res_data` stable; `in_ready`=0 throughout; one-cycle `res_ready` → IDLE next cycle.
- Flush in WAIT (MULH pending) → one-cycle `mul_flush`, `res_valid` never rises, a late `out_valid` is ignored, and the next MUL 3×7 returns 21. With MUL_RESULT_REUSE_EN: MULH a,b then MUL a,b → no second `mul_valid`, `res_valid` at T+1.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared op encodings, FSM states and signedness constants for the RV64M multiply issue control.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } mul_state_e;

    // Bit 1 = multiplicand (rs1) signed, bit 0 = multiplier (rs2) signed.
    localparam logic [1:0] SGN_UU = 2'b00;
    localparam logic [1:0] SGN_US = 2'b01;
    localparam logic [1:0] SGN_SU = 2'b10;
    localparam logic [1:0] SGN_SS = 2'b11;

    // W-form only keeps the low 32 product bits, which do not depend on signedness.
    function automatic logic [1:0] op_signedness(input mul_op_e op, input logic w);
        logic [1:0] sgn;
        sgn = SGN_UU;
        if (!w) begin
            case (op)
                MUL_OP_MULH:   sgn = SGN_SS;
                MUL_OP_MULHSU: sgn = SGN_SU;
                default:       sgn = SGN_UU;
            endcase
        end
        return sgn;
    endfunction

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Op-request, multiplier-core and writeback signals of mul_issue_ctrl; slave = the controller.
interface mul_issue_ctrl_if #(
    parameter int XLEN = 64
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic            in_w;
    logic [XLEN-1:0] in_src1;
    logic [XLEN-1:0] in_src2;

    logic            mul_valid;
    logic            mul_ready;
    logic            mul_flush;
    logic            mulw;
    logic [1:0]      mul_signed;
    logic [XLEN-1:0] multiplicand;
    logic [XLEN-1:0] multiplier;
    logic            out_valid;
    logic [XLEN-1:0] result_hi;
    logic [XLEN-1:0] result_lo;

    logic            res_valid;
    logic            res_ready;
    logic [XLEN-1:0] res_data;

    modport master (
        output flush, in_valid, in_op, in_w, in_src1, in_src2,
        output mul_ready, out_valid, result_hi, result_lo, res_ready,
        input  in_ready, mul_valid, mul_flush, mulw, mul_signed,
        input  multiplicand, multiplier, res_valid, res_data
    );

    modport slave (
        input  flush, in_valid, in_op, in_w, in_src1, in_src2,
        input  mul_ready, out_valid, result_hi, result_lo, res_ready,
        output in_ready, mul_valid, mul_flush, mulw, mul_signed,
        output multiplicand, multiplier, res_valid, res_data
    );
endinterface

// File: rtl/mul_result_fmt.sv
// Formats a 128-bit product into the 64-bit writeback value for MUL/MULH/MULHSU/MULHU/MULW.
module mul_result_fmt
    import mul_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  mul_op_e         op,
    input  logic            w,
    input  logic [XLEN-1:0] result_hi,
    input  logic [XLEN-1:0] result_lo,
    output logic [XLEN-1:0] res_data
);

    always_comb begin
        if (w) begin
            res_data = {{(XLEN-32){result_lo[31]}}, result_lo[31:0]};
        end else if (op == MUL_OP_MUL) begin
            res_data = result_lo;
        end else begin
            res_data = result_hi;
        end
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue control between M-extension decode and the 64-bit multiplier core.
// Optional MUL_RESULT_REUSE_EN: answer a repeated op from the last captured product without a core request.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int XLEN = 64
) (
    input logic             clk,
    input logic             rst,
    mul_issue_ctrl_if.slave bus
);

    mul_state_e      state_q, state_d;
    mul_op_e         op_q, op_d;
    logic            w_q, w_d;
    logic [XLEN-1:0] src1_q, src1_d;
    logic [XLEN-1:0] src2_q, src2_d;
    logic [XLEN-1:0] res_data_q, res_data_d;
    logic            mul_flush_q, mul_flush_d;

    mul_op_e         in_op_n;
    mul_op_e         fmt_op;
    logic            fmt_w;
    logic [XLEN-1:0] fmt_hi;
    logic [XLEN-1:0] fmt_lo;
    logic [XLEN-1:0] fmt_res;

    // An illegal W-form of a high-half op executes as MULW.
    assign in_op_n = bus.in_w ? MUL_OP_MUL : mul_op_e'(bus.in_op);

`ifdef MUL_RESULT_REUSE_EN
    logic [XLEN-1:0] prod_hi_q, prod_hi_d;
    logic [XLEN-1:0] prod_lo_q, prod_lo_d;
    logic [XLEN-1:0] tag_src1_q, tag_src1_d;
    logic [XLEN-1:0] tag_src2_q, tag_src2_d;
    logic [1:0]      tag_sgn_q, tag_sgn_d;
    logic            tag_w_q, tag_w_d;
    logic            tag_valid_q, tag_valid_d;
    logic [1:0]      in_sgn;
    logic            tag_hit;

    assign in_sgn = op_signedness(in_op_n, bus.in_w);
    // A plain MUL only needs the low 64 bits, which every non-W signedness produces identically.
    assign tag_hit = tag_valid_q
                     && (bus.in_src1 == tag_src1_q) && (bus.in_src2 == tag_src2_q)
                     && (bus.in_w == tag_w_q)
                     && ((in_sgn == tag_sgn_q) || (!bus.in_w && in_op_n == MUL_OP_MUL));

    // The formatter serves the stored product on accept and the live core product in WAIT.
    assign fmt_op = (state_q == IDLE) ? in_op_n    : op_q;
    assign fmt_w  = (state_q == IDLE) ? bus.in_w   : w_q;
    assign fmt_hi = (state_q == IDLE) ? prod_hi_q  : bus.result_hi;
    assign fmt_lo = (state_q == IDLE) ? prod_lo_q  : bus.result_lo;
`else
    assign fmt_op = op_q;
    assign fmt_w  = w_q;
    assign fmt_hi = bus.result_hi;
    assign fmt_lo = bus.result_lo;
`endif

    mul_result_fmt #(.XLEN(XLEN)) u_fmt (
        .op        (fmt_op),
        .w         (fmt_w),
        .result_hi (fmt_hi),
        .result_lo (fmt_lo),
        .res_data  (fmt_res)
    );

    always_comb begin
        // NOTE: every *_d gets its hold value first, so no path through the case infers a latch.
        state_d     = state_q;
        op_d        = op_q;
        w_d         = w_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        res_data_d  = res_data_q;
        mul_flush_d = 1'b0;
`ifdef MUL_RESULT_REUSE_EN
        prod_hi_d   = prod_hi_q;
        prod_lo_d   = prod_lo_q;
        tag_src1_d  = tag_src1_q;
        tag_src2_d  = tag_src2_q;
        tag_sgn_d   = tag_sgn_q;
        tag_w_d     = tag_w_q;
        tag_valid_d = tag_valid_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.in_valid && !bus.flush) begin
                    op_d    = in_op_n;
                    w_d     = bus.in_w;
                    src1_d  = bus.in_src1;
                    src2_d  = bus.in_src2;
                    state_d = REQ;
`ifdef MUL_RESULT_REUSE_EN
                    if (tag_hit) begin
                        res_data_d = fmt_res;
                        state_d    = DONE;
                    end
`endif
                end
            end
            REQ: begin
                if (bus.flush) begin
                    mul_flush_d = 1'b1;
                    state_d     = IDLE;
                end else if (bus.mul_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.flush) begin
                    mul_flush_d = 1'b1;
                    state_d     = IDLE;
                end else if (bus.out_valid) begin
                    res_data_d = fmt_res;
                    state_d    = DONE;
`ifdef MUL_RESULT_REUSE_EN
                    prod_hi_d   = bus.result_hi;
                    prod_lo_d   = bus.result_lo;
                    tag_src1_d  = src1_q;
                    tag_src2_d  = src2_q;
                    tag_sgn_d   = op_signedness(op_q, w_q);
                    tag_w_d     = w_q;
                    tag_valid_d = 1'b1;
`endif
                end
            end
            DONE: begin
                if (bus.flush || bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= MUL_OP_MUL;
            w_q         <= 1'b0;
            src1_q      <= '0;
            src2_q      <= '0;
            res_data_q  <= '0;
            mul_flush_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            w_q         <= w_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            res_data_q  <= res_data_d;
            mul_flush_q <= mul_flush_d;
        end
    end

`ifdef MUL_RESULT_REUSE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_q <= 1'b0;
        end else begin
            tag_valid_q <= tag_valid_d;
        end
    end

    // NOTE: product/tag storage is not reset; it is never used while tag_valid_q is low.
    always_ff @(posedge clk) begin
        prod_hi_q  <= prod_hi_d;
        prod_lo_q  <= prod_lo_d;
        tag_src1_q <= tag_src1_d;
        tag_src2_q <= tag_src2_d;
        tag_sgn_q  <= tag_sgn_d;
        tag_w_q    <= tag_w_d;
    end
`endif

    assign bus.in_ready     = (state_q == IDLE);
    assign bus.mul_valid    = (state_q == REQ);
    assign bus.res_valid    = (state_q == DONE);
    assign bus.mul_flush    = mul_flush_q;
    assign bus.mulw         = w_q;
    assign bus.mul_signed   = op_signedness(op_q, w_q);
    assign bus.multiplicand = src1_q;
    assign bus.multiplier   = src2_q;
    assign bus.res_data     = res_data_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl: behavioural core model plus request/result scoreboards.
module tb_mul_issue_ctrl;

    typedef struct packed {
        logic [63:0] src1;
        logic [63:0] src2;
        logic [1:0]  sgn;
        logic        w;
    } req_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    req_t        req_q[$];
    logic [63:0] res_q[$];

    int core_st           = 0;
    int core_lat          = 3;
    int core_ignore_flush = 0;
    int rdy_wait          = 0;
    int lat_cnt           = 0;
    logic [63:0]  cap_a, cap_b;
    logic [1:0]   cap_s;
    logic [127:0] core_p;

    always #5 clk = ~clk;

    mul_issue_ctrl_if #(.XLEN(64)) bus ();

    mul_issue_ctrl #(.XLEN(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_sgn(input logic [1:0] op, input logic w);
        if (w) return 2'b00;
        case (op)
            2'd1:    return 2'b11;
            2'd2:    return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [127:0] ext_mul(input logic [63:0] a, input logic [63:0] b,
                                             input logic sa, input logic sb);
        logic [127:0] ea, eb;
        ea = sa ? {{64{a[63]}}, a} : {64'b0, a};
        eb = sb ? {{64{b[63]}}, b} : {64'b0, b};
        return ea * eb;
    endfunction

    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic w,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [63:0]  pw;
        logic [127:0] p;
        if (w) begin
            pw = {32'b0, a[31:0]} * {32'b0, b[31:0]};
            return {{32{pw[31]}}, pw[31:0]};
        end
        case (op)
            2'd0: begin p = ext_mul(a, b, 1'b0, 1'b0); return p[63:0];   end
            2'd1: begin p = ext_mul(a, b, 1'b1, 1'b1); return p[127:64]; end
            2'd2: begin p = ext_mul(a, b, 1'b1, 1'b0); return p[127:64]; end
            default: begin p = ext_mul(a, b, 1'b0, 1'b0); return p[127:64]; end
        endcase
    endfunction

    // Multiplier core model: random accept delay, fixed latency, single-cycle out_valid.
    initial begin
        bus.mul_ready = 1'b0;
        bus.out_valid = 1'b0;
        bus.result_hi = '0;
        bus.result_lo = '0;
        forever begin
            @(negedge clk);
            bus.out_valid = 1'b0;
            if (bus.mul_flush && core_ignore_flush == 0) begin
                bus.mul_ready = 1'b0;
                core_st = 0;
            end else begin
                case (core_st)
                    0: begin
                        if (bus.mul_valid) begin
                            if (rdy_wait > 0) begin
                                rdy_wait--;
                            end else begin
                                bus.mul_ready = 1'b1;
                                cap_a = bus.multiplicand;
                                cap_b = bus.multiplier;
                                cap_s = bus.mul_signed;
                                if (req_q.size() == 0) begin
                                    check("unexpected_mul_valid", 64'd1, 64'd0);
                                end else begin
                                    req_t r;
                                    r = req_q.pop_front();
                                    check("req_multiplicand", bus.multiplicand, r.src1);
                                    check("req_multiplier", bus.multiplier, r.src2);
                                    check("req_mul_signed", {62'b0, bus.mul_signed}, {62'b0, r.sgn});
                                    check("req_mulw", {63'b0, bus.mulw}, {63'b0, r.w});
                                end
                                core_st = 1;
                            end
                        end
                    end
                    1: begin
                        bus.mul_ready = 1'b0;
                        lat_cnt = core_lat;
                        core_st = 2;
                    end
                    default: begin
                        if (lat_cnt == 0) begin
                            core_p = ext_mul(cap_a, cap_b, cap_s[1], cap_s[0]);
                            bus.result_hi = core_p[127:64];
                            bus.result_lo = core_p[63:0];
                            bus.out_valid = 1'b1;
                            core_st = 0;
                            rdy_wait = $urandom_range(0, 2);
                        end else begin
                            lat_cnt--;
                        end
                    end
                endcase
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input bit expect_req, input bit expect_res);
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("issue_in_ready", {63'b0, bus.in_ready}, 64'd1);
        bus.in_op    = op;
        bus.in_w     = w;
        bus.in_src1  = a;
        bus.in_src2  = b;
        bus.in_valid = 1'b1;
        if (expect_req) req_q.push_back('{src1: a, src2: b, sgn: exp_sgn(op, w), w: w});
        if (expect_res) res_q.push_back(ref_result(op, w, a, b));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (expect_req) begin
            check("lat_mul_valid", {63'b0, bus.mul_valid}, 64'd1);
        end else begin
            check("reuse_res_valid_t1", {63'b0, bus.res_valid}, 64'd1);
            check("reuse_no_mul_valid", {63'b0, bus.mul_valid}, 64'd0);
        end
        check("busy_in_ready", {63'b0, bus.in_ready}, 64'd0);
    endtask

    task automatic drain(input int hold);
        int n = 0;
        logic [63:0] exp;
        while (!bus.res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.res_valid) begin
            check("res_valid_timeout", 64'd0, 64'd1);
            return;
        end
        if (res_q.size() == 0) begin
            check("unexpected_res_valid", 64'd1, 64'd0);
            return;
        end
        exp = res_q.pop_front();
        check("res_data", bus.res_data, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_res_valid", {63'b0, bus.res_valid}, 64'd1);
            check("hold_res_data", bus.res_data, exp);
            check("hold_in_ready", {63'b0, bus.in_ready}, 64'd0);
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("after_ack_res_valid", {63'b0, bus.res_valid}, 64'd0);
        check("after_ack_in_ready", {63'b0, bus.in_ready}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rv_cnt;
        int ov_seen;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'b00;
        bus.in_w      = 1'b0;
        bus.in_src1   = '0;
        bus.in_src2   = '0;
        bus.res_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_in_ready", {63'b0, bus.in_ready}, 64'd1);
        check("rst_mul_valid", {63'b0, bus.mul_valid}, 64'd0);
        check("rst_mul_flush", {63'b0, bus.mul_flush}, 64'd0);
        check("rst_res_valid", {63'b0, bus.res_valid}, 64'd0);
        check("rst_res_data", bus.res_data, 64'd0);
        check("rst_mulw", {63'b0, bus.mulw}, 64'd0);
        check("rst_mul_signed", {62'b0, bus.mul_signed}, 64'd0);
        check("rst_multiplicand", bus.multiplicand, 64'd0);
        check("rst_multiplier", bus.multiplier, 64'd0);

        issue(2'd0, 1'b0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1);                   drain(0);
        issue(2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1); drain(0);
        issue(2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1); drain(0);
        issue(2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1); drain(0);
        issue(2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 1, 1);                   drain(0);
        issue(2'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 1, 1);                   drain(0);
        issue(2'd0, 1'b1, 64'd5, 64'd5, 1, 1);                                     drain(0);
        issue(2'd1, 1'b1, 64'hDEAD_0000_0000_0002, 64'd3, 1, 1);                   drain(0);

        // Writeback back-pressure.
        issue(2'd3, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1, 1);
        drain(10);

        // Flush together with in_valid in IDLE: nothing is accepted, no core flush.
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_op    = 2'd0;
        bus.in_w     = 1'b0;
        bus.in_src1  = 64'd9;
        bus.in_src2  = 64'd9;
        @(posedge clk);
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_in_in_ready", {63'b0, bus.in_ready}, 64'd1);
        check("flush_in_mul_valid", {63'b0, bus.mul_valid}, 64'd0);
        check("flush_in_mul_flush", {63'b0, bus.mul_flush}, 64'd0);

        // Flush while a MULH waits on the core; the core answers late anyway.
        core_lat = 20;
        core_ignore_flush = 1;
        issue(2'd1, 1'b0, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1, 0);
        n = 0;
        while (core_st != 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("flush_core_busy", {63'b0, bus.mul_valid}, 64'd0);
        bus.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_mul_flush_pulse", {63'b0, bus.mul_flush}, 64'd1);
        check("flush_to_idle", {63'b0, bus.in_ready}, 64'd1);
        check("flush_res_valid", {63'b0, bus.res_valid}, 64'd0);
        @(negedge clk);
        check("flush_mul_flush_one_cycle", {63'b0, bus.mul_flush}, 64'd0);
        rv_cnt  = 0;
        ov_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.res_valid) rv_cnt++;
            if (bus.out_valid) ov_seen = 1;
        end
        check("late_out_valid_ignored", 64'(rv_cnt), 64'd0);
        check("late_out_valid_driven", 64'(ov_seen), 64'd1);
        core_lat = 3;
        core_ignore_flush = 0;

        issue(2'd0, 1'b0, 64'd3, 64'd7, 1, 1);
        drain(0);

`ifdef MUL_RESULT_REUSE_EN
        issue(2'd1, 1'b0, 64'hA5A5_0000_1234_0001, 64'hF00D_0000_0000_0077, 1, 1); drain(0);
        issue(2'd0, 1'b0, 64'hA5A5_0000_1234_0001, 64'hF00D_0000_0000_0077, 0, 1); drain(0);
        issue(2'd1, 1'b0, 64'hA5A5_0000_1234_0001, 64'hF00D_0000_0000_0077, 0, 1); drain(0);
`endif

        for (int i = 0; i < 8; i++) begin
            logic [1:0]  op;
            logic        w;
            logic [63:0] a, b;
            op = 2'($urandom_range(0, 3));
            w  = ($urandom_range(0, 3) == 0);
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            issue(op, w, a, b, 1, 1);
            drain($urandom_range(0, 2));
        end

        check("req_queue_empty", 64'(req_q.size()), 64'd0);
        check("res_queue_empty", 64'(res_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
